muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
Iterative multiply/divide sequencer that time-shares one 32-bit add/subtract unit over 32 cycles.
It implements shift-add multiply and restoring divide, using start/busy/done handshaking.
It sits beside the single-cycle ALU and serves the M-extension ops that the ALU cannot finish in one cycle.
The core stalls its PC while busy=1.

Parameters:
XLEN, 32, operand/result width; 32 is the only supported value.
CNT_W, $clog2(XLEN), iteration counter width.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
start  in  1  request pulse; sampled only while busy=0
op  in  3  operation, encoding in muldiv_pkg
a  in  XLEN  multiplicand / dividend
b  in  XLEN  multiplier / divisor
busy  out  1  operation in progress
done  out  1  one-cycle pulse; result valid
result  out  XLEN  result, held until the next accepted start

Behaviour:
- Op encoding: 000 MUL (low 32 bits), 001 MULHU, 010 DIVU, 011 REMU, 100 MUL, 101 MULH (signed×signed), 110 DIV, 111 REM.
- Reset (any time, including mid-operation): state=IDLE; busy=0, done=0, result=0; all internal registers cleared.
- States:
  - IDLE: start=1 latches a, b, op, clears the accumulator, sets count=0, goes to CALC.
  - CALC: one iteration per cycle. At count=XLEN-1 the next state is FIX if SIGNED_MULDIV_EN is defined, else DONE.
  - FIX: one cycle of sign correction, then DONE.
  - DONE: done=1 and result updated. If start=1 it behaves as IDLE (back-to-back accept); else goes to IDLE.
- busy=1 in CALC and FIX; 0 in IDLE and DONE.
- start while busy=1 is ignored; the latched operands are unaffected.
- Latency, with start sampled at edge N:
  - done high after edge N+32 (N+33 with feature).
  - Latency is constant for every op and operand value; there is no early exit.
- Multiply: 65-bit {carry, hi, lo}, lo preloaded with multiplier.
  - Each cycle: if lo[0]=1 then hi = hi + mcand (adder cin=0).
  - Then shift {cout, hi, lo} right by 1.
  - MUL returns lo; MULHU/MULH return hi.
- Divide: 33-bit partial remainder R, quotient Q preloaded with dividend.
  - Each cycle: shift {R, Q} left by 1, then trial = R - divisor (adder cin=1, b inverted).
  - Adder cout=1 means borrow.
  - If R[32]=1 or no borrow: R = trial, Q[0]=1. Else restore (R unchanged), Q[0]=0.
  - DIVU/DIV return Q; REMU/REM return R[31:0].
- Divide by zero needs no special path and must yield: quotient 0xFFFFFFFF, remainder = dividend.
- The adder is the only arithmetic resource in CALC; no `*`, `/` or `%` operators anywhere.
- Without the feature, op[2] is ignored: MULH, DIV and REM execute as MULHU, DIVU and REMU.

Optional Feature:
SIGNED_MULDIV_EN.
- Defined:
  - On accept, op[2]=1 with op[1:0]≠00 (MULH/DIV/REM) stores |a| and |b| plus the sign flags.
  - FIX negates the result when needed: product sign = sa^sb; quotient sign = sa^sb; remainder takes the dividend sign.
  - Divide by zero returns quotient 0xFFFFFFFF (not negated) and remainder = a.
  - Overflow 0x80000000 / 0xFFFFFFFF returns quotient 0x80000000, remainder 0.
  - FIX is entered for every op, so latency stays constant at 33.
- Undefined: FIX state, abs/negate logic and sign registers are absent; latency is 32.

Decomposition:
- muldiv_pkg:
  - XLEN localparam.
  - op_e enum (8 codes above).
  - state_e enum {IDLE, CALC, FIX, DONE}.
  - OP_SIGNED_BIT index.
- One sub-module: a single instance of the team's fullAdder32b (cin selects subtract, cout = borrow for subtract). Operands are muxed by state and op; it is not duplicated.

Test Plan:
- MUL a=7, b=6 -> done exactly 32 cycles after start (33 with feature), result=42, busy high throughout.
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0xFFFFFFFE; MUL with the same operands -> 0x00000001.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 0x1234/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234.
- Start DIVU 100/7, pulse start with MUL 3×3 at cycle 5 -> second start ignored, result=14. Start issued in the DONE cycle -> accepted, back-to-back.
- Assert rst at cycle 10 of a DIVU -> busy=0, done=0, result=0 immediately (asynchronously); no done pulse follows. A new start afterwards completes normally.
- With SIGNED_MULDIV_EN:
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
  - REM -7/2 -> 0xFFFFFFFF; DIV -7/2 -> 0xFFFFFFFD.
  - MULH -2×3 -> 0xFFFFFFFF.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
// The optional signed path is controlled by the SIGNED_MULDIV_EN macro in muldiv_seq.
package muldiv_pkg;

    localparam int XLEN          = 32;
    localparam int CNT_W         = $clog2(XLEN);
    localparam int OP_SIGNED_BIT = 2;

    // M-extension operation codes as presented on the op port
    typedef enum logic [2:0] {
        OP_MUL     = 3'b000,
        OP_MULHU   = 3'b001,
        OP_DIVU    = 3'b010,
        OP_REMU    = 3'b011,
        OP_MUL_ALT = 3'b100,
        OP_MULH    = 3'b101,
        OP_DIV     = 3'b110,
        OP_REM     = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_e;

    // Magnitude of a two's-complement value; the most negative value maps to itself,
    // which is still the correct unsigned magnitude
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v);
        return v[XLEN-1] ? -v : v;
    endfunction

endpackage

// File: rtl/fullAdder32b.sv
// 32-bit add/subtract unit. cin=1 selects subtract (a - b as a + ~b + 1),
// and in that mode cout reports a borrow rather than a carry.
module fullAdder32b (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] b_eff;
    logic [32:0] raw;

    // Invert b for subtract, add with carry-in, and flip the carry into a borrow
    always_comb begin
        b_eff = cin ? ~b : b;
        raw   = {1'b0, a} + {1'b0, b_eff} + {32'd0, cin};
        sum   = raw[31:0];
        cout  = cin ? ~raw[32] : raw[32];
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer: shift-add multiply and restoring divide
// sharing one fullAdder32b over 32 cycles, with start/busy/done handshaking.
// Optional feature macro: SIGNED_MULDIV_EN adds MULH/DIV/REM sign handling
// (operand magnitudes on accept plus a one-cycle FIX state that negates the result).
module muldiv_seq
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q;
    logic [1:0]        kind_q;
    logic [XLEN-1:0]   opnd_q, hi_q, lo_q, hi_d, lo_d;
    logic [XLEN:0]     rem_shift;
    logic [XLEN-1:0]   add_a, add_b, add_sum;
    logic              add_cin, add_cout;
    logic              accept, last_iter;
    logic [XLEN-1:0]   a_ld, b_ld;

`ifdef SIGNED_MULDIV_EN
    logic              signed_op, sa_q, sb_q, fix_neg;
    logic [XLEN-1:0]   raw_res;

    assign signed_op = op[OP_SIGNED_BIT] && (op[1:0] != 2'b00);
    assign a_ld      = signed_op ? abs_val(a) : a;
    assign b_ld      = signed_op ? abs_val(b) : b;
`else
    logic              unused_op_sign;

    assign a_ld           = a;
    assign b_ld           = b;
    assign unused_op_sign = op[OP_SIGNED_BIT];
`endif

    assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_iter = (count_q == CNT_W'(XLEN - 1));
    assign busy      = (state_q == CALC) || (state_q == FIX);
    assign done      = (state_q == DONE);

    fullAdder32b u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; DONE re-accepts a start so operations can run back to back
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = CALC;
`ifdef SIGNED_MULDIV_EN
            CALC: if (last_iter) state_d = FIX;
`else
            CALC: if (last_iter) state_d = DONE;
`endif
            FIX:  state_d = DONE;
            DONE: state_d = start ? CALC : IDLE;
        endcase
    end

    // Adder operand steering: one add (multiply) or trial subtract (divide) per CALC cycle,
    // and in FIX the negation of the finished result
    always_comb begin
        rem_shift = {hi_q, lo_q[XLEN-1]};
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        if (state_q == CALC) begin
            if (kind_q[1]) begin
                add_a   = rem_shift[XLEN-1:0];
                add_b   = opnd_q;
                add_cin = 1'b1;
            end else begin
                add_a   = hi_q;
                add_b   = lo_q[0] ? opnd_q : '0;
            end
        end
`ifdef SIGNED_MULDIV_EN
        else if (state_q == FIX) begin
            add_cin = 1'b1;
            if (kind_q == 2'b01) begin
                // high word of the 64-bit negation: ~hi, plus one only when lo is zero
                add_a = ~hi_q;
                add_b = {XLEN{lo_q == '0}};
            end else begin
                add_b = kind_q[0] ? hi_q : lo_q;
            end
        end
`endif
    end

    // One iteration: multiply shifts {cout, hi, lo} right; divide keeps the trial
    // difference when the shifted remainder overflowed or no borrow occurred
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (kind_q[1]) begin
            if (rem_shift[XLEN] || !add_cout) begin
                hi_d = add_sum;
                lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_d = rem_shift[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_d = {add_cout, add_sum[XLEN-1:1]};
            lo_d = {add_sum[0], lo_q[XLEN-1:1]};
        end
    end

`ifdef SIGNED_MULDIV_EN
    // Sign correction decision: products and quotients follow sa^sb (a zero divisor keeps
    // the all-ones quotient), remainders follow the dividend
    always_comb begin
        fix_neg = 1'b0;
        raw_res = kind_q[0] ? hi_q : lo_q;
        unique case (kind_q)
            2'b01:   fix_neg = sa_q ^ sb_q;
            2'b10:   fix_neg = (sa_q ^ sb_q) && (opnd_q != '0);
            2'b11:   fix_neg = sa_q;
            default: fix_neg = 1'b0;
        endcase
    end
`endif

    // Datapath registers: latch operands on accept, iterate in CALC, publish the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            kind_q  <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            result  <= '0;
`ifdef SIGNED_MULDIV_EN
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
`endif
        end else if (accept) begin
            count_q <= '0;
            kind_q  <= op[1:0];
            hi_q    <= '0;
            if (op[1]) begin
                lo_q   <= a_ld;
                opnd_q <= b_ld;
            end else begin
                lo_q   <= b_ld;
                opnd_q <= a_ld;
            end
`ifdef SIGNED_MULDIV_EN
            sa_q    <= signed_op && a[XLEN-1];
            sb_q    <= signed_op && b[XLEN-1];
`endif
        end else if (state_q == CALC) begin
            count_q <= count_q + 1'b1;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifndef SIGNED_MULDIV_EN
            if (last_iter) result <= kind_q[0] ? hi_d : lo_d;
`endif
        end
`ifdef SIGNED_MULDIV_EN
        else if (state_q == FIX) begin
            result <= fix_neg ? add_sum : raw_res;
        end
`endif
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases, handshake corner cases,
// asynchronous reset mid-operation and randomized operations against a reference model.
// Honours SIGNED_MULDIV_EN the same way the design does.
module tb_muldiv_seq;
    import muldiv_pkg::*;

`ifdef SIGNED_MULDIV_EN
    localparam int LAT = 33;
`else
    localparam int LAT = 32;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    muldiv_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference model computed directly from the M-extension arithmetic rules
    function automatic logic [31:0] refModel(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] up;
        longint      sp;
        int          sx, sy;
        logic        signed_op;
        signed_op = 1'b0;
`ifdef SIGNED_MULDIV_EN
        signed_op = o[2] && (o[1:0] != 2'b00);
`endif
        sx = x;
        sy = y;
        up = {32'd0, x} * {32'd0, y};
        sp = longint'(sx) * longint'(sy);
        if (signed_op) begin
            case (o[1:0])
                2'b01:   return sp[63:32];
                2'b10: begin
                    if (y == 0) return 32'hFFFF_FFFF;
                    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                    return sx / sy;
                end
                default: begin
                    if (y == 0) return x;
                    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
                    return sx % sy;
                end
            endcase
        end
        case (o[1:0])
            2'b00:   return up[31:0];
            2'b01:   return up[63:32];
            2'b10:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    // Present one start pulse at a falling edge; scramble operand inputs afterwards
    task automatic driveStart(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Wait (bounded) for done; k0 is the number of cycles already elapsed since accept
    task automatic waitDone(input string tag, input logic [31:0] exp, input int k0);
        int   k;
        logic busy_ok;
        k       = k0;
        busy_ok = 1'b1;
        while (!done && k < LAT + 20) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            k++;
        end
        checkOutput({tag, "_lat"}, k, LAT);
        checkOutput({tag, "_busy"}, busy_ok, 1);
        checkOutput({tag, "_idlebusy"}, busy, 0);
        checkOutput({tag, "_res"}, result, exp);
    endtask

    // Full single operation: start, wait for done, then check the pulse ends and result holds
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input string tag, input logic [31:0] exp);
        driveStart(o, x, y);
        waitDone(tag, exp, 0);
        @(negedge clk);
        checkOutput({tag, "_pulse"}, done, 0);
        checkOutput({tag, "_hold"}, result, exp);
    endtask

    // Safety net in case something stalls outside the bounded waits
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] corner_vals [6];
        logic [31:0] x, y;
        logic [2:0]  o;
        logic        saw;
        corner_vals = '{32'h0, 32'h1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h2};

        // Reset state
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_result", result, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed unsigned cases
        applyStimulus(OP_MUL,   32'd7,         32'd6,         "mul7x6",    32'd42);
        applyStimulus(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max", 32'hFFFF_FFFE);
        applyStimulus(OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max",   32'h0000_0001);
        applyStimulus(OP_DIVU,  32'd100,       32'd7,         "divu100_7", 32'd14);
        applyStimulus(OP_REMU,  32'd100,       32'd7,         "remu100_7", 32'd2);
        applyStimulus(OP_DIVU,  32'h1234,      32'd0,         "divu_by0",  32'hFFFF_FFFF);
        applyStimulus(OP_REMU,  32'h1234,      32'd0,         "remu_by0",  32'h1234);

        // Start while busy is ignored
        driveStart(OP_DIVU, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = OP_MUL;
        a     = 32'd3;
        b     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        waitDone("ignore", 32'd14, 5);
        @(negedge clk);
        checkOutput("ignore_nodone", done, 0);
        checkOutput("ignore_nobusy", busy, 0);

        // Back-to-back accept in the DONE cycle
        driveStart(OP_DIVU, 32'd100, 32'd7);
        waitDone("b2b_first", 32'd14, 0);
        driveStart(OP_REMU, 32'd100, 32'd7);
        waitDone("b2b_second", 32'd2, 0);
        @(negedge clk);

        // Asynchronous reset in the middle of a divide
        driveStart(OP_DIVU, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_result", result, 0);
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (LAT + 8) begin
            @(negedge clk);
            if (done || busy) saw = 1'b1;
        end
        checkOutput("midrst_quiet", saw, 0);
        applyStimulus(OP_DIVU, 32'd1000, 32'd3, "after_rst", 32'd333);

`ifdef SIGNED_MULDIV_EN
        // Directed signed cases
        applyStimulus(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf",   32'h8000_0000);
        applyStimulus(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf",   32'h0);
        applyStimulus(OP_REM,  32'hFFFF_FFF9, 32'd2,         "rem_m7_2",  32'hFFFF_FFFF);
        applyStimulus(OP_DIV,  32'hFFFF_FFF9, 32'd2,         "div_m7_2",  32'hFFFF_FFFD);
        applyStimulus(OP_MULH, 32'hFFFF_FFFE, 32'd3,         "mulh_m2x3", 32'hFFFF_FFFF);
        applyStimulus(OP_DIV,  32'hFFFF_FFF9, 32'd0,         "div_by0_s", 32'hFFFF_FFFF);
        applyStimulus(OP_REM,  32'hFFFF_FFF9, 32'd0,         "rem_by0_s", 32'hFFFF_FFF9);
`endif

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: begin x = $urandom; y = $urandom; end
                1: begin x = $urandom; y = 32'($urandom_range(0, 15)); end
                2: begin x = $urandom; y = 32'd0; end
                default: begin
                    x = corner_vals[$urandom_range(0, 5)];
                    y = corner_vals[$urandom_range(0, 5)];
                end
            endcase
            applyStimulus(o, x, y, $sformatf("rand%0d_op%0d", i, o), refModel(o, x, y));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
